// File: rtl/trackball_pkg.sv
// trackball_pkg: shared trackball link defaults and step direction encoding
package trackball_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int FILT_DEF = 2;
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;
  function automatic logic step_up(input logic dir, input logic flip);
    return (dir ^ flip) == DIR_POS;
  endfunction
endpackage

// File: rtl/trackball_decoder_if.sv
// trackball_decoder_if: step inputs and position outputs of the trackball decoder
interface trackball_decoder_if #(parameter int CNT_W = 4);
  logic ce;
  logic flip;
  logic h_dir;
  logic h_clk;
  logic v_dir;
  logic v_clk;
  logic sample;
  logic [CNT_W-1:0] h_pos;
  logic [CNT_W-1:0] v_pos;
  logic [CNT_W-1:0] h_live;
  logic [CNT_W-1:0] v_live;
  logic step_seen;
  modport master (
    output ce, flip, h_dir, h_clk, v_dir, v_clk, sample,
    input h_pos, v_pos, h_live, v_live, step_seen
  );
  modport slave (
    input ce, flip, h_dir, h_clk, v_dir, v_clk, sample,
    output h_pos, v_pos, h_live, v_live, step_seen
  );
endinterface

// File: rtl/tb_axis.sv
// tb_axis: synchroniser, glitch filter and wrapping position counter for one axis
module tb_axis
  import trackball_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FILT = FILT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic flip,
  input  logic dir,
  input  logic step,
  input  logic sample,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] live,
  output logic seen
);
  logic [1:0] s_sync;
  logic [1:0] d_sync;
  logic lvl;
  logic pend;
  logic up;
  logic [3:0] fcnt;
  logic hit;
  assign hit = ce && (s_sync[1] != lvl) && (fcnt == 4'(FILT - 1));
  // accept filtered level, latch direction at acceptance, apply the step one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      s_sync <= '0;
      d_sync <= '0;
      lvl <= 1'b0;
      fcnt <= '0;
      pend <= 1'b0;
      up <= 1'b0;
      live <= '0;
      pos <= '0;
      seen <= 1'b0;
    end else begin
      s_sync <= {s_sync[0], step};
      d_sync <= {d_sync[0], dir};
      if (ce) fcnt <= (hit || s_sync[1] == lvl) ? 4'd0 : fcnt + 4'd1;
      if (hit) lvl <= s_sync[1];
      pend <= hit && s_sync[1];
      up <= hit ? step_up(d_sync[1], flip) : up;
      live <= pend ? live + (up ? CNT_W'(1) : '1) : live;
      pos <= sample ? live : pos;
      seen <= pend;
    end
  end
endmodule

// File: rtl/trackball_decoder.sv
// trackball_decoder: two independent filtered step counters with CPU snapshots
module trackball_decoder
  import trackball_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FILT = FILT_DEF
) (
  input logic clk,
  input logic reset,
  trackball_decoder_if.slave bus
);
  logic h_seen;
  logic v_seen;
  tb_axis #(.CNT_W(CNT_W), .FILT(FILT)) u_h (
    .clk(clk), .reset(reset), .ce(bus.ce), .flip(bus.flip), .dir(bus.h_dir),
    .step(bus.h_clk), .sample(bus.sample), .pos(bus.h_pos), .live(bus.h_live), .seen(h_seen)
  );
  tb_axis #(.CNT_W(CNT_W), .FILT(FILT)) u_v (
    .clk(clk), .reset(reset), .ce(bus.ce), .flip(bus.flip), .dir(bus.v_dir),
    .step(bus.v_clk), .sample(bus.sample), .pos(bus.v_pos), .live(bus.v_live), .seen(v_seen)
  );
  assign bus.step_seen = h_seen | v_seen;
endmodule

// File: tb/tb_trackball_decoder.sv
// tb_trackball_decoder: table-driven and directed checks of the trackball decoder
module tb_trackball_decoder;
  import trackball_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int nsteps = 0;
  int base;
  trackball_decoder_if #(.CNT_W(4)) bus ();
  trackball_decoder #(.CNT_W(4), .FILT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.step_seen === 1'b1) nsteps++;
  typedef struct {
    bit rst; int hn; bit hd; int vn; bit vd; bit fl; bit smp;
    int ehl; int evl; int ehp; int evp; int est;
  } vec_t;
  vec_t vecs [6];
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask
  task automatic pulses(input int hn, input int vn);
    for (int i = 0; i < ((hn > vn) ? hn : vn); i++) begin
      bus.h_clk = (i < hn);
      bus.v_clk = (i < vn);
      tick(4);
      bus.h_clk = 1'b0;
      bus.v_clk = 1'b0;
      tick(4);
    end
    tick(8);
  endtask
  task automatic strobe();
    bus.sample = 1'b1;
    tick(1);
    bus.sample = 1'b0;
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_hl"}, int'(bus.h_live), 0);
    chk({name, "_vl"}, int'(bus.v_live), 0);
    chk({name, "_hp"}, int'(bus.h_pos), 0);
    chk({name, "_vp"}, int'(bus.v_pos), 0);
    chk({name, "_seen"}, int'(bus.step_seen), 0);
  endtask
  initial begin
    vecs[0] = '{1, 3, DIR_POS, 0, DIR_POS, 0, 1, 3, 0, 3, 0, 3};
    vecs[1] = '{0, 0, DIR_POS, 5, DIR_NEG, 0, 1, 3, 11, 3, 11, 5};
    vecs[2] = '{0, 0, DIR_POS, 5, DIR_POS, 0, 0, 3, 0, 3, 11, 5};
    vecs[3] = '{1, 2, DIR_POS, 0, DIR_POS, 1, 0, 14, 0, 0, 0, 2};
    vecs[4] = '{0, 1, DIR_POS, 0, DIR_POS, 0, 0, 15, 0, 0, 0, 1};
    vecs[5] = '{0, 1, DIR_POS, 1, DIR_POS, 0, 1, 0, 1, 0, 1, 1};
    bus.ce = 1'b1; bus.flip = 1'b0; bus.sample = 1'b0;
    bus.h_dir = 1'b1; bus.h_clk = 1'b0; bus.v_dir = 1'b1; bus.v_clk = 1'b0;
    tick(2);
    do_reset();
    chk_zero("reset");
    for (int i = 0; i < 6; i++) begin
      bus.flip = vecs[i].fl;
      bus.h_dir = vecs[i].hd;
      bus.v_dir = vecs[i].vd;
      if (vecs[i].rst) do_reset();
      base = nsteps;
      pulses(vecs[i].hn, vecs[i].vn);
      if (vecs[i].smp) strobe();
      tick(1);
      chk($sformatf("v%0d_hl", i), int'(bus.h_live), vecs[i].ehl);
      chk($sformatf("v%0d_vl", i), int'(bus.v_live), vecs[i].evl);
      chk($sformatf("v%0d_hp", i), int'(bus.h_pos), vecs[i].ehp);
      chk($sformatf("v%0d_vp", i), int'(bus.v_pos), vecs[i].evp);
      chk($sformatf("v%0d_steps", i), nsteps - base, vecs[i].est);
    end
    bus.flip = 1'b0; bus.h_dir = DIR_POS;
    base = nsteps;
    bus.h_clk = 1'b1;
    tick(1);
    bus.h_clk = 1'b0;
    tick(12);
    chk("glitch_hl", int'(bus.h_live), 0);
    chk("glitch_steps", nsteps - base, 0);
    base = nsteps;
    bus.ce = 1'b0;
    bus.h_clk = 1'b1;
    tick(4);
    bus.h_clk = 1'b0;
    tick(4);
    bus.ce = 1'b1;
    tick(8);
    chk("ce_off_hl", int'(bus.h_live), 0);
    chk("ce_off_steps", nsteps - base, 0);
    bus.h_clk = 1'b1;
    tick(4);
    chk("lat_early_hl", int'(bus.h_live), 0);
    chk("lat_early_seen", int'(bus.step_seen), 0);
    tick(1);
    chk("lat_hl", int'(bus.h_live), 1);
    chk("lat_seen", int'(bus.step_seen), 1);
    tick(1);
    chk("lat_seen_drop", int'(bus.step_seen), 0);
    bus.h_clk = 1'b0;
    tick(8);
    do_reset();
    pulses(6, 0);
    chk("land_pre_hl", int'(bus.h_live), 6);
    bus.h_clk = 1'b1;
    tick(4);
    strobe();
    chk("land_hp", int'(bus.h_pos), 6);
    chk("land_hl", int'(bus.h_live), 7);
    tick(1);
    chk("land_hold_hp", int'(bus.h_pos), 6);
    strobe();
    chk("land_next_hp", int'(bus.h_pos), 7);
    bus.h_clk = 1'b0;
    tick(8);
    bus.h_clk = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk_zero("rst_mid");
    tick(1);
    chk_zero("rst_high");
    reset = 1'b0;
    base = nsteps;
    tick(10);
    chk("rst_rel_hl", int'(bus.h_live), 1);
    chk("rst_rel_steps", nsteps - base, 1);
    bus.h_clk = 1'b0;
    tick(8);
    chk("rst_final_hl", int'(bus.h_live), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
